tl_ul_reg_adapter: RTL and testbench
====================================

TL_UL_REG_ADAPTER -- requirements
Module: tl_ul_reg_adapter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 32, address bits; DATA_WIDTH, 32, data bits; MASK_WIDTH, DATA_WIDTH/8, byte-enable bits; SIZE_WIDTH, 3, size bits; OPCODE_WIDTH, 3, opcode bits; PARAM_WIDTH, 3, param bits; TIMEOUT, 16, register-bus wait limit in cycles (2..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset_n, in, 1, async active-low reset.
- a_valid, in, 1, Channel A request valid.
- a_ready, out, 1, Channel A accept.
- a_opcode, in, OPCODE_WIDTH, 0=PutFullData, 1=PutPartialData, 4=Get.
- a_param, in, PARAM_WIDTH, ignored.
- a_size, in, SIZE_WIDTH, log2 bytes.
- a_source, in, 1, requester ID.
- a_address, in, ADDR_WIDTH, byte address.
- a_mask, in, MASK_WIDTH, byte lanes.
- a_data, in, DATA_WIDTH, write data.
- d_valid, out, 1, Channel D response valid.
- d_ready, in, 1, Channel D accept.
- d_opcode, out, OPCODE_WIDTH, 0=AccessAck, 1=AccessAckData.
- d_param, out, PARAM_WIDTH, always 0.
- d_size, out, SIZE_WIDTH, echo of a_size.
- d_source, out, 1, echo of a_source.
- d_sink, out, 1, always 0.
- d_data, out, DATA_WIDTH, read data.
- d_error, out, 1, access error.
- reg_req, out, 1, register-bus request.
- reg_we, out, 1, 1=write.
- reg_addr, out, ADDR_WIDTH, word-aligned address (low 2 bits 0).
- reg_wdata, out, DATA_WIDTH, write data.
- reg_be, out, MASK_WIDTH, byte enables.
- reg_ack, in, 1, access complete.
- reg_rdata, in, DATA_WIDTH, read data, valid with reg_ack.
- reg_err, in, 1, slave error, valid with reg_ack.

Function
REQ-004 SHALL implement FSM IDLE, BUS, RESP; a_ready=1 only in IDLE; one transaction outstanding.
REQ-005 SHALL capture all A fields on a_valid&&a_ready; d_size/d_source driven from captured values.
REQ-006 SHALL flag illegal request when opcode not in {0,1,4}, a_size>2, or address not aligned to 2^a_size; illegal -> RESP next cycle, d_error=1, d_data=0, no reg_req.
REQ-007 SHALL on legal request go to BUS: reg_req=1 from cycle after acceptance, reg_we=(opcode!=4), reg_be=captured mask, reg_addr/reg_wdata stable until exit.
REQ-008 SHALL on reg_ack in BUS drop reg_req the next cycle, enter RESP, d_data=reg_rdata for Get else 0, d_error=reg_err.
REQ-009 SHALL count BUS cycles with 8-bit counter cleared on entry; after TIMEOUT cycles without reg_ack, enter RESP with d_error=1, d_data=0.
REQ-010 SHALL give reg_ack priority over timeout when both occur in the same cycle.
REQ-011 SHALL ignore reg_ack outside BUS.
REQ-012 SHALL in RESP hold d_valid=1 and all D fields stable until d_ready; on d_valid&&d_ready return to IDLE (a_ready=1 next cycle).
REQ-013 SHALL set d_opcode=1 for Get, 0 for Put, including error responses.
REQ-014 SHALL keep d_param=0 and d_sink=0 always.
REQ-015 SHALL give legal-request latency: accept at N, reg_ack at M>=N+1, d_valid at M+1.

Reset
REQ-016 SHALL on reset_n=0 immediately enter IDLE with a_ready=1, d_valid=0, reg_req=0, reg_we=0, counter=0, and all D/reg data outputs 0.
REQ-017 SHALL abandon any in-flight transaction on reset with no response issued.

Verification
REQ-018 Get 0x10, size 2, reg_ack after 3 cycles, rdata 0xDEADBEEF -> d_valid, opcode 1, data 0xDEADBEEF, error 0.
REQ-019 PutPartialData 0x20, mask 0x3, data 0x1234 -> reg_we=1, reg_be=0x3; after ack d_opcode 0, d_error 0.
REQ-020 Get 0x02, size 2 -> no reg_req; d_valid next cycle, d_error 1, d_data 0.
REQ-021 TIMEOUT=4, no reg_ack -> reg_req high 4 cycles, then d_error 1; late reg_ack ignored.
REQ-022 d_ready held 0 for 5 cycles -> D fields stable, a_ready 0; reset_n pulse in BUS -> reg_req 0, a_ready 1 immediately.

Source files
------------

// File: rtl/tl_ul_reg_adapter.sv
// TileLink-UL (Get/PutFull/PutPartial) to simple req/ack register-bus adapter.
// One transaction outstanding; all outputs registered.
module tl_ul_reg_adapter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned PARAM_WIDTH  = 3,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic                    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic                    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [MASK_WIDTH-1:0]   reg_be,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [7:0]              CNT_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    a_ready_q;
    logic                    d_valid_q;
    logic [OPCODE_WIDTH-1:0] d_opcode_q;
    logic [SIZE_WIDTH-1:0]   d_size_q;
    logic                    d_source_q;
    logic [DATA_WIDTH-1:0]   d_data_q;
    logic                    d_error_q;
    logic                    reg_req_q;
    logic                    reg_we_q;
    logic [ADDR_WIDTH-1:0]   reg_addr_q;
    logic [DATA_WIDTH-1:0]   reg_wdata_q;
    logic [MASK_WIDTH-1:0]   reg_be_q;
    logic [7:0]              cnt_q;
    logic                    is_get_q;

    logic                    misaligned_c;
    logic                    illegal_c;
    logic                    a_is_get_c;
    logic                    unused_inputs;

    // a_param carries no meaning for this slave
    assign unused_inputs = ^a_param;

    // Request legality: supported opcode, size up to a word, naturally aligned
    always_comb begin
        misaligned_c = 1'b0;
        case (a_size)
            SIZE_WIDTH'(0): misaligned_c = 1'b0;
            SIZE_WIDTH'(1): misaligned_c = a_address[0];
            SIZE_WIDTH'(2): misaligned_c = |a_address[1:0];
            default:        misaligned_c = 1'b1;
        endcase
        a_is_get_c = (a_opcode == OP_GET);
        illegal_c  = !((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART) || a_is_get_c)
                     || (a_size > SIZE_WIDTH'(2)) || misaligned_c;
    end

    // Transaction FSM with all channel and register-bus outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_ready_q   <= 1'b1;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= 1'b0;
            d_data_q    <= '0;
            d_error_q   <= 1'b0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_be_q    <= '0;
            cnt_q       <= 8'd0;
            is_get_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (a_valid && a_ready_q) begin
                        a_ready_q  <= 1'b0;
                        d_size_q   <= a_size;
                        d_source_q <= a_source;
                        is_get_q   <= a_is_get_c;
                        cnt_q      <= 8'd0;
                        if (illegal_c) begin
                            state_q    <= ST_RESP;
                            d_valid_q  <= 1'b1;
                            d_opcode_q <= a_is_get_c ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
                            d_error_q  <= 1'b1;
                            d_data_q   <= '0;
                        end else begin
                            state_q     <= ST_BUS;
                            reg_req_q   <= 1'b1;
                            reg_we_q    <= !a_is_get_c;
                            reg_addr_q  <= {a_address[ADDR_WIDTH-1:2], 2'b00};
                            reg_wdata_q <= a_data;
                            reg_be_q    <= a_mask;
                        end
                    end
                end
                ST_BUS: begin
                    if (reg_ack || (cnt_q == CNT_LAST)) begin
                        state_q    <= ST_RESP;
                        reg_req_q  <= 1'b0;
                        reg_we_q   <= 1'b0;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= is_get_q ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
                        // reg_ack wins over a coincident timeout
                        d_error_q  <= reg_ack ? reg_err : 1'b1;
                        d_data_q   <= (reg_ack && is_get_q) ? reg_rdata : '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (d_ready) begin
                        state_q   <= ST_IDLE;
                        d_valid_q <= 1'b0;
                        a_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    a_ready_q <= 1'b1;
                    d_valid_q <= 1'b0;
                    reg_req_q <= 1'b0;
                    reg_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_ready   = a_ready_q;
    assign d_valid   = d_valid_q;
    assign d_opcode  = d_opcode_q;
    assign d_param   = '0;
    assign d_size    = d_size_q;
    assign d_source  = d_source_q;
    assign d_sink    = 1'b0;
    assign d_data    = d_data_q;
    assign d_error   = d_error_q;
    assign reg_req   = reg_req_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_be    = reg_be_q;

endmodule

// File: tb/tb_tl_ul_reg_adapter.sv
// Bench for tl_ul_reg_adapter: directed corner cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_tl_ul_reg_adapter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        reg_req;
    logic        reg_we;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        reg_err;

    int n_cmp = 0;
    int n_err = 0;

    tl_ul_reg_adapter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
        .d_error(d_error),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_be(reg_be), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: ack_dly >= TO means the slave never answers.
    task automatic do_txn(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [3:0] msk, input logic [31:0] wd, input logic src,
                          input int ack_dly, input logic [31:0] rd, input logic er,
                          input int dr_dly);
        logic        illegal;
        logic        acked;
        int unsigned align;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [31:0] hold_data;
        align   = 32'd1 << sz;
        illegal = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (sz > 3'd2) || ((addr % align) != 0);
        chk("a_ready_idle", 64'(a_ready), 64'd1);
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr;
        a_mask = msk; a_data = wd; a_source = src; a_param = 3'($urandom_range(0, 7));
        tick();
        a_valid = 1'b0;
        a_opcode = 3'($urandom); a_address = $urandom; a_size = 3'($urandom); a_source = 1'($urandom);
        exp_err  = 1'b1;
        exp_data = 32'd0;
        if (illegal) begin
            chk("illegal_no_req", 64'(reg_req), 64'd0);
        end else begin
            acked = 1'b0;
            for (int k = 0; k < int'(TO) && !acked; k++) begin
                chk("bus_req", 64'(reg_req), 64'd1);
                chk("bus_a_ready", 64'(a_ready), 64'd0);
                chk("bus_d_valid", 64'(d_valid), 64'd0);
                chk("bus_we", 64'(reg_we), 64'(op != 3'd4));
                chk("bus_addr", 64'(reg_addr), 64'(addr & 32'hFFFF_FFFC));
                chk("bus_wdata", 64'(reg_wdata), 64'(wd));
                chk("bus_be", 64'(reg_be), 64'(msk));
                if (k == ack_dly) begin
                    reg_ack = 1'b1; reg_rdata = rd; reg_err = er;
                    acked = 1'b1;
                    exp_err  = er;
                    exp_data = (op == 3'd4) ? rd : 32'd0;
                end
                tick();
                reg_ack = 1'b0; reg_rdata = $urandom; reg_err = 1'($urandom);
            end
            chk("resp_req_low", 64'(reg_req), 64'd0);
        end
        chk("resp_valid", 64'(d_valid), 64'd1);
        chk("resp_opcode", 64'(d_opcode), 64'(op == 3'd4));
        chk("resp_error", 64'(d_error), 64'(exp_err));
        chk("resp_data", 64'(d_data), 64'(exp_data));
        chk("resp_size", 64'(d_size), 64'(sz));
        chk("resp_source", 64'(d_source), 64'(src));
        chk("resp_param_sink", 64'({d_param, d_sink}), 64'd0);
        hold_data = d_data;
        for (int k = 0; k < dr_dly; k++) begin
            // stray acks outside BUS must not disturb the response
            reg_ack = 1'($urandom); reg_rdata = $urandom; reg_err = 1'($urandom);
            tick();
            reg_ack = 1'b0;
            chk("hold_valid", 64'(d_valid), 64'd1);
            chk("hold_a_ready", 64'(a_ready), 64'd0);
            chk("hold_data", 64'(d_data), 64'(hold_data));
            chk("hold_error", 64'(d_error), 64'(exp_err));
            chk("hold_req", 64'(reg_req), 64'd0);
        end
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk("done_valid", 64'(d_valid), 64'd0);
        chk("done_a_ready", 64'(a_ready), 64'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] addr;
        reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = 1'b0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_reg_req", 64'(reg_req), 64'd0);
        chk("rst_reg_we", 64'(reg_we), 64'd0);
        chk("rst_d_data", 64'(d_data), 64'd0);
        chk("rst_reg_addr", 64'(reg_addr), 64'd0);
        chk("rst_reg_wdata", 64'(reg_wdata), 64'd0);
        reset_n = 1'b1;
        tick();

        // Get with ack after 3 cycles
        do_txn(3'd4, 3'd2, 32'h10, 4'hF, 32'h0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 0);
        // PutPartialData
        do_txn(3'd1, 3'd2, 32'h20, 4'h3, 32'h1234, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, 1);
        // misaligned Get
        do_txn(3'd4, 3'd2, 32'h02, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0);
        // timeout with no ack, response held 5 cycles with stray acks
        do_txn(3'd0, 3'd2, 32'h40, 4'hF, 32'hCAFE, 1'b1, int'(TO), 32'h0, 1'b0, 5);
        // ack coinciding with the final timeout cycle
        do_txn(3'd4, 3'd2, 32'h44, 4'hF, 32'h0, 1'b0, int'(TO) - 1, 32'h5A5A_A5A5, 1'b1, 2);
        // bad opcode and oversize
        do_txn(3'd2, 3'd0, 32'h48, 4'h1, 32'h0, 1'b1, 0, 32'h0, 1'b0, 0);
        do_txn(3'd4, 3'd3, 32'h50, 4'hF, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0);

        // reset pulse while in BUS abandons the transaction
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_address = 32'h60; a_mask = 4'hF;
        tick();
        a_valid = 1'b0;
        chk("pre_rst_req", 64'(reg_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_req", 64'(reg_req), 64'd0);
        chk("async_rst_a_ready", 64'(a_ready), 64'd1);
        chk("async_rst_d_valid", 64'(d_valid), 64'd0);
        tick();
        reset_n = 1'b1;
        reg_ack = 1'b1; reg_rdata = 32'h1111_2222;
        tick();
        reg_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_no_resp", 64'(d_valid), 64'd0);
            chk("post_rst_no_req", 64'(reg_req), 64'd0);
            tick();
        end

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0: op = 3'd0;
                1: op = 3'd1;
                2: op = 3'd4;
                default: op = 3'($urandom);
            endcase
            sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            do_txn(op, sz, addr, 4'($urandom), $urandom, 1'($urandom),
                   int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
